mmc1_sync_mapper: RTL

// MMC1-class Famicom mapper core, CLK-synchronous: samples the CPU bus with a fast system clock

---
 rtl/mmc1_sync_mapper_if.sv | 31 +++
 rtl/mmc1_sync_mapper.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mmc1_sync_mapper_if.sv
// Cartridge-edge bus bundle for the MMC1 sync mapper: CPU/PPU inputs and ROM/RAM selects.
// master = console/edge side driving the bus, slave = mapper core.
interface mmc1_sync_mapper_if;
    logic       cpu_m2;
    logic       cpu_a13;
    logic       cpu_a14;
    logic       n_cpu_romsel;
    logic       n_cpu_rw;
    logic       cpu_d0;
    logic       cpu_d7;
    logic       ppu_a12;
    logic       ppu_a11;
    logic       ppu_a10;
    logic [4:0] prg_a;
    logic [4:0] chr_a;
    logic       ciram_a10;
    logic       n_prg_ce;
    logic       n_wram_ce;

    modport master (
        output cpu_m2, cpu_a13, cpu_a14, n_cpu_romsel, n_cpu_rw, cpu_d0, cpu_d7,
        output ppu_a12, ppu_a11, ppu_a10,
        input  prg_a, chr_a, ciram_a10, n_prg_ce, n_wram_ce
    );

    modport slave (
        input  cpu_m2, cpu_a13, cpu_a14, n_cpu_romsel, n_cpu_rw, cpu_d0, cpu_d7,
        input  ppu_a12, ppu_a11, ppu_a10,
        output prg_a, chr_a, ciram_a10, n_prg_ce, n_wram_ce
    );
endinterface

// File: rtl/mmc1_sync_mapper.sv
// MMC1-class mapper clocked by a fast system clock: synchronises the CPU bus, commits serial
// writes on the M2 falling edge, filters back-to-back (RMW) writes and supports SUROM paging.
module mmc1_sync_mapper #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          WRITE_FILTER = 1'b1,
    parameter bit          SUROM_EN     = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mmc1_sync_mapper_if.slave io_bus
);

    // Captured bus fields: {nROMSEL, nRW, A13, A14, D0, D7}
    localparam int unsigned BitRomselN = 5;
    localparam int unsigned BitRwN     = 4;
    localparam int unsigned BitA13     = 3;
    localparam int unsigned BitA14     = 2;
    localparam int unsigned BitD0      = 1;
    localparam int unsigned BitD7      = 0;

    logic [SYNC_STAGES-1:0] r_m2_sync;
    logic [5:0]             r_bus_sync [SYNC_STAGES];
    logic                   r_m2_prev;
    logic [5:0]             r_cap;
    logic                   r_prev_wr;
    logic [4:0]             r_load;
    logic [4:0]             r_control;
    logic [4:0]             r_chr_b0;
    logic [4:0]             r_chr_b1;
    logic [4:0]             r_prg_b;

    logic       w_m2_s;
    logic [5:0] w_bus_raw;
    logic [5:0] w_bus_s;
    logic       w_end;
    logic       w_wr;
    logic       w_filtered;
    logic [4:0] w_shift;
    logic [3:0] w_prg_lo;
    logic       w_prg_hi;

    assign w_bus_raw = {io_bus.n_cpu_romsel, io_bus.n_cpu_rw, io_bus.cpu_a13,
                        io_bus.cpu_a14, io_bus.cpu_d0, io_bus.cpu_d7};

    assign w_m2_s     = r_m2_sync[SYNC_STAGES-1];
    assign w_bus_s    = r_bus_sync[SYNC_STAGES-1];
    assign w_end      = r_m2_prev & ~w_m2_s;
    assign w_wr       = w_end & ~r_cap[BitRomselN] & ~r_cap[BitRwN];
    assign w_filtered = WRITE_FILTER & r_prev_wr;
    assign w_shift    = {r_cap[BitD0], r_load[4:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m2_sync <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_bus_sync[i] <= '0;
            end
            r_m2_prev <= 1'b0;
            r_cap     <= '0;
            r_prev_wr <= 1'b0;
            r_load    <= 5'b10000;
            r_control <= 5'b01100;
            r_chr_b0  <= '0;
            r_chr_b1  <= '0;
            r_prg_b   <= '0;
        end else begin
            // M2 and the bus fields share one chain depth so they stay cycle-aligned
            r_m2_sync[0]  <= io_bus.cpu_m2;
            r_bus_sync[0] <= w_bus_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_m2_sync[i]  <= r_m2_sync[i-1];
                r_bus_sync[i] <= r_bus_sync[i-1];
            end
            r_m2_prev <= w_m2_s;
            if (w_m2_s) begin
                r_cap <= w_bus_s;
            end
            if (w_end) begin
                r_prev_wr <= w_wr;
            end
            if (w_wr) begin
                if (r_cap[BitD7]) begin
                    r_load    <= 5'b10000;
                    r_control <= r_control | 5'b01100;
                end else if (!w_filtered) begin
                    if (!r_load[0]) begin
                        r_load <= w_shift;
                    end else begin
                        unique case ({r_cap[BitA14], r_cap[BitA13]})
                            2'b00:   r_control <= w_shift;
                            2'b01:   r_chr_b0  <= w_shift;
                            2'b10:   r_chr_b1  <= w_shift;
                            default: r_prg_b   <= w_shift;
                        endcase
                        r_load <= 5'b10000;
                    end
                end
            end
        end
    end

    always_comb begin
        w_prg_lo = '0;
        unique case (r_control[3:2])
            2'b00, 2'b01: w_prg_lo = {r_prg_b[3:1], io_bus.cpu_a14};
            2'b10:        w_prg_lo = io_bus.cpu_a14 ? r_prg_b[3:0] : 4'b0000;
            default:      w_prg_lo = io_bus.cpu_a14 ? 4'b1111 : r_prg_b[3:0];
        endcase
    end

    assign w_prg_hi     = SUROM_EN ? r_chr_b0[4] : 1'b0;
    assign io_bus.prg_a = {w_prg_hi, w_prg_lo};

    assign io_bus.chr_a = r_control[4] ? (io_bus.ppu_a12 ? r_chr_b1 : r_chr_b0)
                                       : {r_chr_b0[4:1], io_bus.ppu_a12};

    always_comb begin
        io_bus.ciram_a10 = 1'b0;
        unique case (r_control[1:0])
            2'b00:   io_bus.ciram_a10 = 1'b0;
            2'b01:   io_bus.ciram_a10 = 1'b1;
            2'b10:   io_bus.ciram_a10 = io_bus.ppu_a10;
            default: io_bus.ciram_a10 = io_bus.ppu_a11;
        endcase
    end

    // Chip enables come straight from the raw bus so ROM/RAM timing is not delayed
    assign io_bus.n_prg_ce  = io_bus.n_cpu_romsel | ~io_bus.n_cpu_rw;
    assign io_bus.n_wram_ce = ~(io_bus.cpu_m2 & io_bus.n_cpu_romsel & io_bus.cpu_a14 &
                                io_bus.cpu_a13 & ~r_prg_b[4]);

endmodule
